// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit -- instruction fetch stage with a single PC register.
//
// Fetches one instruction per request from a combinational instruction
// memory. The word address is held on imem_pc for WAIT_CYCLES cycles, then
// imem_instr is captured into ir and ir_valid is raised. The instruction is
// held until control acknowledges it. The acknowledge advances pc
// sequentially or by a signed branch offset. Leaving the program range
// parks the unit in HALT until reset.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   fetch_req         request the next instruction
//   imem_pc/instr     instruction memory address out / instruction in
//   ir, pc, ir_valid  fetched instruction, its address, valid flag
//   ir_ack            consume ir (only honoured while ir_valid)
//   br_taken/offset   redirect next fetch to pc+1+sext(br_offset)
//   halted            fetch stopped (pc left 0..PROG_LENGTH)
//   fetch_count       saturating count of consumed instructions
// ---------------------------------------------------------------------------
module ifetch_unit #(
   parameter int unsigned PROG_LENGTH = 31,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [31:0] RESET_PC    = 32'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_req,
   output logic [31:0] imem_pc,
   input  logic [31:0] imem_instr,
   output logic [31:0] ir,
   output logic [31:0] pc,
   output logic        ir_valid,
   input  logic        ir_ack,
   input  logic        br_taken,
   input  logic [15:0] br_offset,
   output logic        halted,
   output logic [15:0] fetch_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_VALID,
      S_HALT
   } state_t;

   localparam logic [3:0]  WAIT_LD   = 4'(WAIT_CYCLES);
   localparam logic [31:0] PROG_LAST = 32'(PROG_LENGTH);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] fcnt_q, fcnt_d;

   logic [31:0] pc_seq, br_ext, pc_next;

   // Next address is relative to pc+1; wraps modulo 2^32 so a backward
   // branch from a low pc lands far above PROG_LENGTH and halts.
   assign pc_seq  = pc_q + 32'd1;
   assign br_ext  = {{16{br_offset[15]}}, br_offset};
   assign pc_next = br_taken ? (pc_seq + br_ext) : pc_seq;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      cnt_d   = cnt_q;
      fcnt_d  = fcnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (fetch_req) begin
               state_d = S_FETCH;
               cnt_d   = WAIT_LD;
            end
         end
         S_FETCH: begin
            // Capture on the edge that ends the last wait cycle.
            if (cnt_q <= 4'd1) begin
               ir_d    = imem_instr;
               cnt_d   = 4'd0;
               state_d = S_VALID;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_VALID: begin
            if (ir_ack) begin
               pc_d = pc_next;
               if (fcnt_q != 16'hFFFF) fcnt_d = fcnt_q + 16'd1;
               if (pc_next > PROG_LAST) begin
                  state_d = S_HALT;
               end else if (fetch_req) begin
                  state_d = S_FETCH;
                  cnt_d   = WAIT_LD;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_HALT: ;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         ir_q    <= 32'd0;
         cnt_q   <= 4'd0;
         fcnt_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign imem_pc     = pc_q;
   assign pc          = pc_q;
   assign ir          = ir_q;
   assign ir_valid    = (state_q == S_VALID);
   assign halted      = (state_q == S_HALT);
   assign fetch_count = fcnt_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ifetch_unit -- directed bench for ifetch_unit.
// Instance A: WAIT_CYCLES=1, PROG_LENGTH=22 (branching, end of program,
// wrap-around). Instance B: WAIT_CYCLES=3, PROG_LENGTH=31 (latency, ignored
// ack outside VALID, reset mid-fetch).
// ---------------------------------------------------------------------------
module tb_ifetch_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Memory image: words 0 and 1 fixed, others tagged with their address.
   function automatic logic [31:0] mem(input logic [31:0] a);
      case (a)
         32'd0:   mem = 32'hE400FFFF;
         32'd1:   mem = 32'hE800FFFF;
         default: mem = {16'hC0DE, a[15:0]};
      endcase
   endfunction

   // ---------------- instance A ----------------
   logic        rst_n_a = 1'b0, fetch_req_a = 1'b0, ir_ack_a = 1'b0, br_taken_a = 1'b0;
   logic [15:0] br_offset_a = 16'd0;
   logic [31:0] imem_pc_a, imem_instr_a, ir_a, pc_a;
   logic        ir_valid_a, halted_a;
   logic [15:0] fetch_count_a;

   assign imem_instr_a = mem(imem_pc_a);

   ifetch_unit #(.PROG_LENGTH(22), .WAIT_CYCLES(1), .RESET_PC(32'd0)) u_a (
      .clk(clk), .rst_n(rst_n_a), .fetch_req(fetch_req_a),
      .imem_pc(imem_pc_a), .imem_instr(imem_instr_a),
      .ir(ir_a), .pc(pc_a), .ir_valid(ir_valid_a),
      .ir_ack(ir_ack_a), .br_taken(br_taken_a), .br_offset(br_offset_a),
      .halted(halted_a), .fetch_count(fetch_count_a)
   );

   // ---------------- instance B ----------------
   logic        rst_n_b = 1'b0, fetch_req_b = 1'b0, ir_ack_b = 1'b0, br_taken_b = 1'b0;
   logic [15:0] br_offset_b = 16'd0;
   logic [31:0] imem_pc_b, imem_instr_b, ir_b, pc_b;
   logic        ir_valid_b, halted_b;
   logic [15:0] fetch_count_b;

   assign imem_instr_b = mem(imem_pc_b);

   ifetch_unit #(.PROG_LENGTH(31), .WAIT_CYCLES(3), .RESET_PC(32'd0)) u_b (
      .clk(clk), .rst_n(rst_n_b), .fetch_req(fetch_req_b),
      .imem_pc(imem_pc_b), .imem_instr(imem_instr_b),
      .ir(ir_b), .pc(pc_b), .ir_valid(ir_valid_b),
      .ir_ack(ir_ack_b), .br_taken(br_taken_b), .br_offset(br_offset_b),
      .halted(halted_b), .fetch_count(fetch_count_b)
   );

   // Addresses 19/20 must never appear on imem_pc during the branch phase.
   logic mon_en  = 1'b0;
   logic seen_19 = 1'b0;
   always @(negedge clk)
      if (mon_en && (imem_pc_a == 32'd19 || imem_pc_a == 32'd20)) seen_19 = 1'b1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Acknowledge the instruction in A, then wait one cycle for the refetch.
   task automatic consume_a(input logic br, input logic [15:0] off);
      ir_ack_a = 1'b1; br_taken_a = br; br_offset_a = off;
      step();
      ir_ack_a = 1'b0; br_taken_a = 1'b0; br_offset_a = 16'd0;
      step();
   endtask

   initial begin
      // ---- A: reset state ----
      step(); step();
      chk("rst_pc",      pc_a, 32'd0);
      chk("rst_imem_pc", imem_pc_a, 32'd0);
      chk("rst_ir",      ir_a, 32'd0);
      chk("rst_valid",   {31'd0, ir_valid_a}, 32'd0);
      chk("rst_halted",  {31'd0, halted_a}, 32'd0);
      chk("rst_count",   {16'd0, fetch_count_a}, 32'd0);

      // ---- A: ack/branch in IDLE ignored ----
      rst_n_a = 1'b1; ir_ack_a = 1'b1; br_taken_a = 1'b1; br_offset_a = 16'd5;
      step();
      chk("idle_ack_pc",    pc_a, 32'd0);
      chk("idle_ack_count", {16'd0, fetch_count_a}, 32'd0);
      chk("idle_ack_valid", {31'd0, ir_valid_a}, 32'd0);
      ir_ack_a = 1'b0; br_taken_a = 1'b0; br_offset_a = 16'd0;

      // ---- A: first fetch, one-cycle latency ----
      mon_en = 1'b1;
      fetch_req_a = 1'b1;
      step();
      chk("lat_a_n", {31'd0, ir_valid_a}, 32'd0);
      step();
      chk("lat_a_n1", {31'd0, ir_valid_a}, 32'd1);
      chk("first_ir", ir_a, 32'hE400FFFF);
      chk("first_pc", pc_a, 32'd0);
      step();
      chk("hold_valid", {31'd0, ir_valid_a}, 32'd1);
      chk("hold_ir",    ir_a, 32'hE400FFFF);

      ir_ack_a = 1'b1;
      step();
      ir_ack_a = 1'b0;
      chk("ack_clr_valid", {31'd0, ir_valid_a}, 32'd0);
      chk("ack_pc",        pc_a, 32'd1);
      chk("ack_count",     {16'd0, fetch_count_a}, 32'd1);
      chk("ack_ir_keep",   ir_a, 32'hE400FFFF);
      step();
      chk("second_ir", ir_a, 32'hE800FFFF);
      chk("second_pc", pc_a, 32'd1);

      // ---- A: sequential to 12, branch back to 10 ----
      for (int i = 0; i < 11; i++) consume_a(1'b0, 16'd0);
      chk("seq_pc12", pc_a, 32'd12);
      chk("seq_ir12", ir_a, 32'hC0DE000C);
      consume_a(1'b1, 16'hFFFD);
      chk("brback_pc", pc_a, 32'd10);
      chk("brback_ir", ir_a, 32'hC0DE000A);
      chk("brback_count", {16'd0, fetch_count_a}, 32'd13);

      // ---- A: sequential to 18, jump forward to 21 ----
      for (int i = 0; i < 8; i++) consume_a(1'b0, 16'd0);
      chk("seq_pc18", pc_a, 32'd18);
      consume_a(1'b1, 16'h0002);
      chk("jump_pc", pc_a, 32'd21);
      chk("jump_ir", ir_a, 32'hC0DE0015);
      mon_en = 1'b0;
      chk("skip_19_20", {31'd0, seen_19}, 32'd0);

      // ---- A: sequential run to end of program ----
      rst_n_a = 1'b0;
      step();
      rst_n_a = 1'b1;
      step();
      step();
      chk("eop_start_pc", pc_a, 32'd0);
      for (int i = 0; i < 22; i++) consume_a(1'b0, 16'd0);
      chk("eop_pc22", pc_a, 32'd22);
      ir_ack_a = 1'b1;
      step();
      ir_ack_a = 1'b0;
      chk("eop_halted", {31'd0, halted_a}, 32'd1);
      chk("eop_valid",  {31'd0, ir_valid_a}, 32'd0);
      chk("eop_count",  {16'd0, fetch_count_a}, 32'd23);
      chk("eop_ir",     ir_a, 32'hC0DE0016);
      ir_ack_a = 1'b1; br_taken_a = 1'b1; br_offset_a = 16'h0004;
      step(); step(); step();
      ir_ack_a = 1'b0; br_taken_a = 1'b0; br_offset_a = 16'd0;
      chk("halt_sticky", {31'd0, halted_a}, 32'd1);
      chk("halt_pc",     pc_a, 32'd23);
      chk("halt_count",  {16'd0, fetch_count_a}, 32'd23);

      // ---- A: wrap-around halts ----
      rst_n_a = 1'b0;
      step();
      chk("rst2_halted", {31'd0, halted_a}, 32'd0);
      chk("rst2_count",  {16'd0, fetch_count_a}, 32'd0);
      rst_n_a = 1'b1;
      step(); step();
      chk("wrap_start_pc", pc_a, 32'd0);
      ir_ack_a = 1'b1; br_taken_a = 1'b1; br_offset_a = 16'hFFFD;
      step();
      ir_ack_a = 1'b0; br_taken_a = 1'b0; br_offset_a = 16'd0;
      chk("wrap_pc",     pc_a, 32'hFFFFFFFE);
      chk("wrap_imem",   imem_pc_a, 32'hFFFFFFFE);
      chk("wrap_halted", {31'd0, halted_a}, 32'd1);
      chk("wrap_valid",  {31'd0, ir_valid_a}, 32'd0);
      step(); step(); step();
      chk("wrap_nofetch", {31'd0, ir_valid_a}, 32'd0);
      chk("wrap_pc_hold", pc_a, 32'hFFFFFFFE);
      fetch_req_a = 1'b0;

      // ---- B: three-cycle latency, ack in FETCH ignored ----
      rst_n_b = 1'b1;
      fetch_req_b = 1'b1;
      step();
      fetch_req_b = 1'b0;
      ir_ack_b = 1'b1; br_taken_b = 1'b1; br_offset_b = 16'h0007;
      step();
      chk("lat_b_n1", {31'd0, ir_valid_b}, 32'd0);
      step();
      chk("lat_b_n2", {31'd0, ir_valid_b}, 32'd0);
      ir_ack_b = 1'b0; br_taken_b = 1'b0; br_offset_b = 16'd0;
      step();
      chk("lat_b_n3", {31'd0, ir_valid_b}, 32'd1);
      chk("b_ir",     ir_b, 32'hE400FFFF);
      chk("b_pc",     pc_b, 32'd0);
      chk("b_count",  {16'd0, fetch_count_b}, 32'd0);
      ir_ack_b = 1'b1;
      step();
      ir_ack_b = 1'b0;
      chk("b_idle_pc",    pc_b, 32'd1);
      chk("b_idle_valid", {31'd0, ir_valid_b}, 32'd0);
      step(); step(); step(); step();
      chk("b_idle_stay", {31'd0, ir_valid_b}, 32'd0);

      // ---- B: reset one cycle after FETCH entry ----
      fetch_req_b = 1'b1;
      step();
      fetch_req_b = 1'b0;
      step();
      rst_n_b = 1'b0;
      step();
      rst_n_b = 1'b1;
      chk("mid_rst_pc",    pc_b, 32'd0);
      chk("mid_rst_ir",    ir_b, 32'd0);
      chk("mid_rst_valid", {31'd0, ir_valid_b}, 32'd0);
      chk("mid_rst_count", {16'd0, fetch_count_b}, 32'd0);
      step(); step(); step(); step();
      chk("mid_rst_novalid", {31'd0, ir_valid_b}, 32'd0);
      chk("mid_rst_ir_hold", ir_b, 32'd0);
      fetch_req_b = 1'b1;
      step();
      fetch_req_b = 1'b0;
      step(); step();
      chk("refetch_n2", {31'd0, ir_valid_b}, 32'd0);
      step();
      chk("refetch_n3", {31'd0, ir_valid_b}, 32'd1);
      chk("refetch_ir", ir_b, 32'hE400FFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
